mod_5to31_monitor: RTL
======================

# mod_5to31_monitor

Passive checker on the receiving end of the 5-to-31 loadable up/down counter interface. It snoops the counter's control inputs (`load`, `I`, `mode`) and its registered output `q`, and runs a cycle-accurate reference model of the counter. It flags every divergence, counts errors, and drops and regains lock via a resync state machine. It sits beside the counter in benches and in FPGA self-test builds.

## Interface
- `WIDTH`, 5: counter data width.
- `MIN`, 5: lowest legal count.
- `MAX`, 31: highest legal count; must equal 2^WIDTH-1 or lower.
- `CNT_W`, 8: error counter width.
- `LOCK_CNT`, 2: consecutive matching cycles in RESYNC needed to relock; minimum 1.
- `clk`  input  1: single clock, shared with the counter; all logic on posedge.
- `rst`  input  1: synchronous, active-high reset, the same net that resets the counter.
- `q`  input  WIDTH: observed counter output.
- `I`  input  WIDTH: observed load value.
- `load`  input  1: observed load strobe.
- `mode`  input  1: observed direction; 0 = up, 1 = down.
- `exp_q`  output  WIDTH: model's expected value of `q` for the current cycle.
- `locked`  output  1: model is tracking the counter.
- `err`  output  1: one-cycle pulse on a value mismatch while locked.
- `range_err`  output  1: one-cycle pulse when `q` < MIN, in any state.
- `viol`  output  1: one-cycle pulse on a protocol violation (`load`=1 with `I` < MIN).
- `err_cnt`  output  CNT_W: saturating count of `err` and `range_err` events.

## Operation
- Counter contract, as decided: `rst` sets q to MIN. Otherwise `load` sets q to I, and `load` has priority over counting. Otherwise up counts q+1 with MAX wrapping to MIN, and down counts q-1 with MIN wrapping to MAX. There is no hold state.
- `next(v)` is that function applied to the snooped `load`/`I`/`mode` and base value v.
- States:
  - TRACK: model register `m` follows `m <= next(m)`.
  - RESYNC: the model adopts the DUT value, `m <= next(q)`; match counter `mc` counts up.
- `exp_q` = `m`. `locked` = 1 exactly in TRACK.
- TRACK with `q != m`:
  - Pulse `err` and increment `err_cnt`.
  - Go to RESYNC with `mc`=0 and `m <= next(q)`.
- RESYNC:
  - `q == m`: `mc` increments. Reaching LOCK_CNT moves the block to TRACK.
  - `q != m`: `mc` clears. No `err`, no count.
- `range_err`:
  - Fires on `q` < MIN in any state and increments `err_cnt`.
  - In TRACK it also forces RESYNC.
  - If `err` fires on the same edge, `err_cnt` increments by 2, saturating.
- `viol`:
  - Fires when `load`=1 and `I` < MIN; the counter's behaviour is then undefined.
  - Forces RESYNC with `mc`=0 and no `err_cnt` change.
  - The compare that would follow is suppressed for that cycle.
- `err_cnt` saturates at 2^CNT_W-1 and clears only on `rst`.
- Arithmetic is WIDTH bits. Wrap is explicit compare-and-select, never natural overflow, because MIN is not 0.

## Timing
- Reset values:
  - State TRACK, `m`=MIN, so `exp_q`=MIN and `locked`=1.
  - `err`, `range_err`, `viol` = 0.
  - `err_cnt`=0, `mc`=0.
- `rst` overrides everything on the same edge, including mid-RESYNC. Counter and model reset together, so there is no lock loss after reset.
- Compare is combinational on `q` against the registered `m`. `err`, `range_err` and `viol` are registered: high for exactly the cycle following the edge at which the offending `q`/`load` was sampled.
- Latency:
  - Mismatch sampled at edge k: `err`=1 and `locked`=0 after edge k.
  - Relock occurs after edge k+LOCK_CNT at the earliest.
- `exp_q` for cycle n+1 is valid immediately after edge n. There is zero-cycle skew versus the counter's `q`.

## Structure
- Package `mod_5to31_pkg`:
  - State enum {TRACK, RESYNC}.
  - Default MIN/MAX/WIDTH constants.
  - The `next` value function, which the counter RTL and this monitor both import so the contract has one definition.
- Sub-module `mod_5to31_model`: registered reference counter with `load`, `I`, `mode`, and a `seed`/`seed_en` override used by RESYNC. The FSM, compare logic and error counter stay in the top.

## Test plan
- Reset, then `load` I=8 at cycle 3, up mode: `q`/`exp_q` follow 8,9,10,…, `locked`=1, `err_cnt`=0.
- Up from 29: 29,30,31,5,6 with no `err`. `mode`=1 from 7: 7,6,5,31,30 with no `err`.
- Force `q`=20 while `exp_q`=12 (up):
  - `err` pulses once, `err_cnt`=1, `locked`=0.
  - `exp_q`=21 next. After 2 matching cycles `locked`=1.
- Force `q`=3 while locked:
  - `range_err` and `err` both pulse, `err_cnt` +2.
  - A subsequent second mismatch during RESYNC does not increment.
- `load`=1, I=2: `viol` pulses, `err_cnt` is unchanged, RESYNC is entered. Assert `rst` mid-RESYNC: `exp_q`=5, `locked`=1, `err_cnt`=0 next cycle.
- CNT_W=2 run with 5 injected mismatches: `err_cnt` holds at 3.

Source files
------------

// File: rtl/mod_5to31_pkg.sv
// Shared definitions for the 5-to-31 loadable up/down counter and its monitor.
// next_val() is the single definition of the counter contract.
package mod_5to31_pkg;

  typedef enum logic {
    TRACK,
    RESYNC
  } state_e;

  localparam int unsigned DEF_WIDTH = 5;
  localparam int unsigned DEF_MIN   = 5;
  localparam int unsigned DEF_MAX   = 31;

  // Wrap is an explicit compare-and-select because the range does not start at 0.
  function automatic int unsigned next_val(
    input logic        ld,
    input int unsigned i,
    input logic        md,
    input int unsigned v,
    input int unsigned mn,
    input int unsigned mx
  );
    int unsigned r;
    if (ld) begin
      r = i;
    end else if (!md) begin
      r = (v >= mx) ? mn : v + 32'd1;
    end else begin
      r = (v <= mn) ? mx : v - 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_5to31_monitor_if.sv
// Snooped counter signals: the counter side drives them, the monitor only listens.
interface mod_5to31_monitor_if #(
  parameter int unsigned WIDTH = 5
);
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] I;
  logic             load;
  logic             mode;

  modport master (output q, I, load, mode);
  modport slave  (input  q, I, load, mode);
endinterface

// File: rtl/mod_5to31_model.sv
// Registered reference counter; seed_en swaps the base value for the observed q.
module mod_5to31_model
  import mod_5to31_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned MIN   = DEF_MIN,
  parameter int unsigned MAX   = DEF_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] I,
  input  logic             mode,
  input  logic [WIDTH-1:0] seed,
  input  logic             seed_en,
  output logic [WIDTH-1:0] m
);

  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] m_d;
  logic [WIDTH-1:0] base;

  always_comb begin
    base = seed_en ? seed : m_q;
    m_d  = WIDTH'(next_val(load, 32'(I), mode, 32'(base), MIN, MAX));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= WIDTH'(MIN);
    end else begin
      m_q <= m_d;
    end
  end

  assign m = m_q;

endmodule

// File: rtl/mod_5to31_monitor.sv
// Passive checker for the 5-to-31 counter: tracks it with a reference model,
// flags divergence, counts errors and relocks through a RESYNC state.
module mod_5to31_monitor
  import mod_5to31_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned MIN      = DEF_MIN,
  parameter int unsigned MAX      = DEF_MAX,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mod_5to31_monitor_if.slave   bus,
  output logic [WIDTH-1:0]     exp_q,
  output logic                 locked,
  output logic                 err,
  output logic                 range_err,
  output logic                 viol,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int unsigned      MC_W   = $clog2(LOCK_CNT + 1);
  localparam logic [MC_W-1:0]  LOCK_V = MC_W'(LOCK_CNT);
  localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN);

  state_e           state_q, state_d;
  logic [MC_W-1:0]  mc_q, mc_d;
  logic             err_q, err_d;
  logic             range_q, range_d;
  logic             viol_q, viol_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] m;
  logic             seed_en;
  logic             mism;
  logic             range_c;
  logic             viol_c;
  logic             clean;
  logic [1:0]       inc;
  logic [CNT_W:0]   sum;

  mod_5to31_model #(
    .WIDTH (WIDTH),
    .MIN   (MIN),
    .MAX   (MAX)
  ) u_model (
    .clk     (clk),
    .rst     (rst),
    .load    (bus.load),
    .I       (bus.I),
    .mode    (bus.mode),
    .seed    (bus.q),
    .seed_en (seed_en),
    .m       (m)
  );

  assign mism    = (bus.q != m);
  assign range_c = (bus.q < MIN_V);
  assign viol_c  = bus.load && (bus.I < MIN_V);
  assign clean   = !mism && !range_c && !viol_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TRACK;
      mc_q      <= '0;
      err_q     <= 1'b0;
      range_q   <= 1'b0;
      viol_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mc_q      <= mc_d;
      err_q     <= err_d;
      range_q   <= range_d;
      viol_q    <= viol_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    case (state_q)
      TRACK: begin
        if (!clean) begin
          state_d = RESYNC;
          mc_d    = '0;
        end
      end
      RESYNC: begin
        if (!clean) begin
          mc_d = '0;
        end else if (mc_q + MC_W'(1) == LOCK_V) begin
          state_d = TRACK;
          mc_d    = '0;
        end else begin
          mc_d = mc_q + MC_W'(1);
        end
      end
      default: begin
        state_d = TRACK;
        mc_d    = '0;
      end
    endcase
  end

  always_comb begin
    // A violation makes the counter undefined, so the value compare is dropped.
    seed_en   = (state_q == RESYNC) || !clean;
    err_d     = (state_q == TRACK) && mism && !viol_c;
    range_d   = range_c;
    viol_d    = viol_c;
    inc       = {1'b0, err_d} + {1'b0, range_d};
    sum       = {1'b0, err_cnt_q} + (CNT_W + 1)'(inc);
    err_cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    locked    = (state_q == TRACK);
    exp_q     = m;
  end

  assign err       = err_q;
  assign range_err = range_q;
  assign viol      = viol_q;
  assign err_cnt   = err_cnt_q;

endmodule
